// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding, default words and
// address helpers.
package fetch_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StWait    = 2'd1,
        StDiscard = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] RESET_ADDR       = 32'hbfc0_0000;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_slot.sv
// Fetch-to-decode output register: loads a fetched instruction, drops it when decode
// consumes it or on a redirect.
module inst_slot (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_load,
    input  logic        i_consume,
    input  logic        i_clear,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_inst,
    input  logic        i_adel,
    output logic        o_valid,
    output logic [31:0] o_pc,
    output logic [31:0] o_inst,
    output logic        o_adel
);

    logic        r_valid;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic        r_adel;

    // A load always wins over consume; the parent never loads while clearing.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_pc    <= 32'h0;
            r_inst  <= 32'h0;
            r_adel  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_pc    <= i_pc;
            r_inst  <= i_inst;
            r_adel  <= i_adel;
        end else if (i_clear || i_consume) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_pc    = r_pc;
    assign o_inst  = r_inst;
    assign o_adel  = r_adel;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage with a single outstanding bus request and flush discard.
// Define FETCH_ADEL_EN to turn misaligned PCs into an address-error slot instead of a fetch.
module inst_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic        fetch_stall,
    input  logic        flush,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic [31:0] inst_rdata,
    input  logic        inst_data_ok,
    input  logic        id_allowin,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_adel
);

    fetch_state_e r_state;
    fetch_state_e w_state_next;
    logic [31:0]  r_req_pc;

    logic        w_slot_free;
    logic        w_pc_misaligned;
    logic        w_issue_ok;
    logic        w_accept;
    logic        w_adel_load;
    logic        w_data_load;
    logic        w_slot_load;
    logic [31:0] w_slot_pc;
    logic [31:0] w_slot_inst;

`ifdef FETCH_ADEL_EN
    assign w_pc_misaligned = (pc[1:0] != 2'b00);
`else
    logic w_unused;
    assign w_pc_misaligned = 1'b0;
    assign w_unused        = ^{pc[1:0], NOP_INST};
`endif

    assign w_slot_free = !id_valid || id_allowin;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_req_pc <= 32'h0;
        end else if (w_accept) begin
            r_req_pc <= pc;
        end
    end

    // Data_ok returns to IDLE from either waiting state; a flush while waiting poisons the reply.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_accept) w_state_next = StWait;
            end
            StWait: begin
                if (inst_data_ok) begin
                    w_state_next = StIdle;
                end else if (flush) begin
                    w_state_next = StDiscard;
                end
            end
            StDiscard: begin
                if (inst_data_ok) w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        w_issue_ok  = (r_state == StIdle) && w_slot_free && !flush && !reset;
        inst_req    = w_issue_ok && !w_pc_misaligned;
        inst_addr   = align_word(pc);
        w_accept    = inst_req && inst_addr_ok;
        w_adel_load = w_issue_ok && w_pc_misaligned;
        fetch_stall = !(w_accept || w_adel_load);
        w_data_load = (r_state == StWait) && inst_data_ok && !flush && !reset;
        w_slot_load = w_data_load || w_adel_load;
        w_slot_pc   = w_adel_load ? pc : r_req_pc;
        w_slot_inst = w_adel_load ? NOP_INST : inst_rdata;
    end

    inst_slot u_inst_slot (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_slot_load),
        .i_consume (id_valid && id_allowin),
        .i_clear   (flush),
        .i_pc      (w_slot_pc),
        .i_inst    (w_slot_inst),
        .i_adel    (w_adel_load),
        .o_valid   (id_valid),
        .o_pc      (id_pc),
        .o_inst    (id_inst),
        .o_adel    (id_adel)
    );

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus a randomized run against a
// transaction-level model of the fetch stage.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        fetch_stall;
    logic        flush;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic [31:0] inst_rdata;
    logic        inst_data_ok;
    logic        id_allowin;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_adel;

    int n_chk = 0;
    int n_err = 0;

    inst_fetch u_dut (
        .clk          (clk),
        .reset        (reset),
        .pc           (pc),
        .fetch_stall  (fetch_stall),
        .flush        (flush),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_rdata   (inst_rdata),
        .inst_data_ok (inst_data_ok),
        .id_allowin   (id_allowin),
        .id_valid     (id_valid),
        .id_pc        (id_pc),
        .id_inst      (id_inst),
        .id_adel      (id_adel)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        pc = 32'hbfc0_0000; id_allowin = 1'b1; inst_addr_ok = 1'b1;
        #1;
        n_chk++; if (inst_req !== 1'b0) begin n_err++; $display("FAIL rst_req got=%0b want=0", inst_req); end
        n_chk++; if (fetch_stall !== 1'b1) begin n_err++; $display("FAIL rst_stall got=%0b want=1", fetch_stall); end
        tick();
        n_chk++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got=%0b want=0", id_valid); end
        n_chk++; if (id_pc !== 32'h0) begin n_err++; $display("FAIL rst_pc got=%h want=0", id_pc); end
        n_chk++; if (id_inst !== 32'h0) begin n_err++; $display("FAIL rst_inst got=%h want=0", id_inst); end
        n_chk++; if (id_adel !== 1'b0) begin n_err++; $display("FAIL rst_adel got=%0b want=0", id_adel); end
        // Stray data_ok in the first cycle after reset must be ignored.
        reset = 1'b0; inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h1234_5678;
        #1;
        n_chk++; if (inst_req !== 1'b1) begin n_err++; $display("FAIL rst_idle_req got=%0b want=1", inst_req); end
        tick();
        inst_data_ok = 1'b0;
        n_chk++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL rst_stray got=%0b want=0", id_valid); end
    endtask

    task automatic test_basic();
        pc = 32'hbfc0_0000; id_allowin = 1'b1; inst_addr_ok = 1'b1;
        #1;
        n_chk++; if (inst_req !== 1'b1) begin n_err++; $display("FAIL basic_req got=%0b want=1", inst_req); end
        n_chk++; if (inst_addr !== 32'hbfc0_0000) begin n_err++; $display("FAIL basic_addr got=%h want=bfc00000", inst_addr); end
        n_chk++; if (fetch_stall !== 1'b0) begin n_err++; $display("FAIL basic_stall got=%0b want=0", fetch_stall); end
        tick();
        inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h2408_0001; pc = 32'hbfc0_0004;
        #1;
        n_chk++; if (inst_req !== 1'b0) begin n_err++; $display("FAIL basic_wait_req got=%0b want=0", inst_req); end
        n_chk++; if (fetch_stall !== 1'b1) begin n_err++; $display("FAIL basic_wait_stall got=%0b want=1", fetch_stall); end
        tick();
        inst_data_ok = 1'b0;
        n_chk++; if (id_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid got=%0b want=1", id_valid); end
        n_chk++; if (id_pc !== 32'hbfc0_0000) begin n_err++; $display("FAIL basic_pc got=%h want=bfc00000", id_pc); end
        n_chk++; if (id_inst !== 32'h2408_0001) begin n_err++; $display("FAIL basic_inst got=%h want=24080001", id_inst); end
        n_chk++; if (id_adel !== 1'b0) begin n_err++; $display("FAIL basic_adel got=%0b want=0", id_adel); end
        tick();
        n_chk++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL basic_consume got=%0b want=0", id_valid); end
    endtask

    task automatic test_addr_wait();
        pc = 32'hbfc0_0004; id_allowin = 1'b1; inst_addr_ok = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_chk++; if (inst_req !== 1'b1) begin n_err++; $display("FAIL aw_req[%0d] got=%0b want=1", i, inst_req); end
            n_chk++; if (fetch_stall !== 1'b1) begin n_err++; $display("FAIL aw_stall[%0d] got=%0b want=1", i, fetch_stall); end
            tick();
        end
        inst_addr_ok = 1'b1;
        #1;
        n_chk++; if (fetch_stall !== 1'b0) begin n_err++; $display("FAIL aw_accept got=%0b want=0", fetch_stall); end
        tick();
        inst_addr_ok = 1'b0;
        #1;
        n_chk++; if (fetch_stall !== 1'b1) begin n_err++; $display("FAIL aw_after got=%0b want=1", fetch_stall); end
        inst_data_ok = 1'b1; inst_rdata = 32'h0000_0aa4;
        tick();
        inst_data_ok = 1'b0;
        n_chk++; if (id_pc !== 32'hbfc0_0004 || id_valid !== 1'b1) begin
            n_err++; $display("FAIL aw_slot got=%b/%h want=1/bfc00004", id_valid, id_pc);
        end
        tick();
    endtask

    task automatic test_backpressure();
        pc = 32'hbfc0_0008; id_allowin = 1'b1; inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'haaaa_0001;
        tick();
        inst_data_ok = 1'b0; id_allowin = 1'b0; pc = 32'hbfc0_000c; inst_addr_ok = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_chk++; if (inst_req !== 1'b0) begin n_err++; $display("FAIL bp_req[%0d] got=%0b want=0", i, inst_req); end
            n_chk++; if (id_valid !== 1'b1 || id_inst !== 32'haaaa_0001) begin
                n_err++; $display("FAIL bp_slot[%0d] got=%b/%h want=1/aaaa0001", i, id_valid, id_inst);
            end
            tick();
        end
        id_allowin = 1'b1;
        #1;
        n_chk++; if (inst_req !== 1'b1) begin n_err++; $display("FAIL bp_release_req got=%0b want=1", inst_req); end
        tick();
        inst_addr_ok = 1'b0;
        n_chk++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL bp_consumed got=%0b want=0", id_valid); end
        inst_data_ok = 1'b1; inst_rdata = 32'hbbbb_0002;
        tick();
        inst_data_ok = 1'b0;
        n_chk++; if (id_inst !== 32'hbbbb_0002 || id_pc !== 32'hbfc0_000c) begin
            n_err++; $display("FAIL bp_second got=%h/%h want=bbbb0002/bfc0000c", id_inst, id_pc);
        end
        tick();
    endtask

    task automatic test_flush();
        pc = 32'hbfc0_0100; id_allowin = 1'b1; inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0; flush = 1'b1; pc = 32'hbfc0_0380;
        #1;
        n_chk++; if (inst_req !== 1'b0) begin n_err++; $display("FAIL fl_wait_req got=%0b want=0", inst_req); end
        tick();
        flush = 1'b0;
        #1;
        n_chk++; if (inst_req !== 1'b0) begin n_err++; $display("FAIL fl_disc_req got=%0b want=0", inst_req); end
        tick();
        inst_data_ok = 1'b1; inst_rdata = 32'hdead_beef;
        tick();
        inst_data_ok = 1'b0;
        n_chk++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL fl_dropped got=%0b want=0", id_valid); end
        #1;
        n_chk++; if (inst_req !== 1'b1 || inst_addr !== 32'hbfc0_0380) begin
            n_err++; $display("FAIL fl_redirect got=%b/%h want=1/bfc00380", inst_req, inst_addr);
        end
        tick();
    endtask

    task automatic test_reset_in_wait();
        pc = 32'hbfc0_0200; id_allowin = 1'b1; inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0; reset = 1'b1;
        #1;
        n_chk++; if (inst_req !== 1'b0 || fetch_stall !== 1'b1) begin
            n_err++; $display("FAIL rw_in_reset got=%b/%b want=0/1", inst_req, fetch_stall);
        end
        tick();
        reset = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h5555_5555;
        #1;
        n_chk++; if (inst_req !== 1'b1) begin n_err++; $display("FAIL rw_idle got=%0b want=1", inst_req); end
        tick();
        inst_data_ok = 1'b0;
        n_chk++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL rw_stray got=%0b want=0", id_valid); end
    endtask

    task automatic test_back_to_back();
        logic        pending;
        logic [31:0] prev_pc;
        logic [31:0] exp_inst;
        logic        delivered;
        int          n_acc;
        pending = 1'b0; prev_pc = 32'h0; n_acc = 0;
        pc = 32'hbfc0_0300; id_allowin = 1'b1;
        for (int i = 0; i < 10; i++) begin
            inst_addr_ok = 1'b1; inst_data_ok = pending; inst_rdata = 32'h1000_0000 + i;
            delivered = pending; exp_inst = inst_rdata;
            #1;
            pending = !fetch_stall;
            tick();
            if (delivered) begin
                n_chk++; if (id_valid !== 1'b1 || id_inst !== exp_inst || id_pc !== prev_pc) begin
                    n_err++; $display("FAIL b2b_slot[%0d] got=%b/%h/%h want=1/%h/%h", i, id_valid,
                                      id_inst, id_pc, exp_inst, prev_pc);
                end
            end
            if (pending) begin
                prev_pc = pc; pc = pc + 32'd4; n_acc++;
            end
        end
        n_chk++; if (n_acc != 5) begin n_err++; $display("FAIL b2b_rate got=%0d want=5", n_acc); end
        inst_addr_ok = 1'b0; inst_data_ok = pending;
        tick();
        inst_data_ok = 1'b0;
        tick();
    endtask

`ifdef FETCH_ADEL_EN
    task automatic test_adel();
        pc = 32'hbfc0_0002; id_allowin = 1'b1; inst_addr_ok = 1'b1;
        #1;
        n_chk++; if (inst_req !== 1'b0 || fetch_stall !== 1'b0) begin
            n_err++; $display("FAIL adel_comb got=%b/%b want=0/0", inst_req, fetch_stall);
        end
        tick();
        pc = 32'hbfc0_0010; inst_addr_ok = 1'b0;
        n_chk++; if (id_valid !== 1'b1 || id_adel !== 1'b1 || id_inst !== 32'h0 ||
                     id_pc !== 32'hbfc0_0002) begin
            n_err++; $display("FAIL adel_slot got=%b/%b/%h/%h want=1/1/0/bfc00002", id_valid,
                              id_adel, id_inst, id_pc);
        end
        tick();
    endtask
`endif

    // Model tracks transactions: one pending request, a poison flag set by flush, and the slot.
    task automatic test_random();
        logic        m_busy, m_drop, m_valid, e_req, e_acc;
        logic [31:0] m_pend_pc, m_pc, m_inst;
        m_busy = 1'b0; m_drop = 1'b0; m_valid = 1'b0;
        m_pend_pc = 32'h0; m_pc = 32'h0; m_inst = 32'h0;
        for (int i = 0; i < 400; i++) begin
            flush        = ($urandom_range(0, 9) == 0);
            id_allowin   = ($urandom_range(0, 3) != 0);
            inst_addr_ok = ($urandom_range(0, 2) != 0);
            inst_data_ok = m_busy && ($urandom_range(0, 1) == 1);
            inst_rdata   = $urandom;
            pc           = $urandom & 32'hffff_fffc;
            #1;
            e_req = !m_busy && (!m_valid || id_allowin) && !flush;
            e_acc = e_req && inst_addr_ok;
            n_chk++; if (inst_req !== e_req) begin n_err++; $display("FAIL rnd_req[%0d] got=%0b want=%0b", i, inst_req, e_req); end
            n_chk++; if (fetch_stall !== !e_acc) begin n_err++; $display("FAIL rnd_stall[%0d] got=%0b want=%0b", i, fetch_stall, !e_acc); end
            if (e_req) begin
                n_chk++; if (inst_addr !== pc) begin n_err++; $display("FAIL rnd_addr[%0d] got=%h want=%h", i, inst_addr, pc); end
            end
            tick();
            if (m_valid && id_allowin) m_valid = 1'b0;
            if (m_busy && inst_data_ok) begin
                if (!m_drop && !flush) begin
                    m_valid = 1'b1; m_pc = m_pend_pc; m_inst = inst_rdata;
                end
                m_busy = 1'b0; m_drop = 1'b0;
            end else if (m_busy && flush) begin
                m_drop = 1'b1;
            end
            if (flush) m_valid = 1'b0;
            if (e_acc) begin
                m_busy = 1'b1; m_pend_pc = pc;
            end
            n_chk++; if (id_valid !== m_valid) begin n_err++; $display("FAIL rnd_valid[%0d] got=%0b want=%0b", i, id_valid, m_valid); end
            if (m_valid) begin
                n_chk++; if (id_pc !== m_pc || id_inst !== m_inst || id_adel !== 1'b0) begin
                    n_err++; $display("FAIL rnd_slot[%0d] got=%h/%h/%b want=%h/%h/0", i, id_pc,
                                      id_inst, id_adel, m_pc, m_inst);
                end
            end
        end
        flush = 1'b0; inst_addr_ok = 1'b0; id_allowin = 1'b1; inst_data_ok = m_busy;
        tick();
        inst_data_ok = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1; pc = 32'h0; flush = 1'b0; inst_addr_ok = 1'b0;
        inst_rdata = 32'h0; inst_data_ok = 1'b0; id_allowin = 1'b0;
        test_reset();
        test_basic();
        test_addr_wait();
        test_backpressure();
        test_flush();
        test_reset_in_wait();
        test_back_to_back();
`ifdef FETCH_ADEL_EN
        test_adel();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter NOP_INST, default 32'h0000_0000, is the instruction word presented to decode on an address-error fetch.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 pc  in  32  fetch address from the PC register.
REQ-005 fetch_stall  out  1  holds the PC register; the PC advances only when this is 0.
REQ-006 flush  in  1  exception or eret redirect, one-cycle pulse.
REQ-007 inst_req  out  1  instruction-bus request valid.
REQ-008 inst_addr  out  32  instruction-bus request address.
REQ-009 inst_addr_ok  in  1  request accepted this cycle.
REQ-010 inst_rdata  in  32  returned instruction.
REQ-011 inst_data_ok  in  1  inst_rdata valid this cycle; cannot be back-pressured.
REQ-012 id_allowin  in  1  decode consumes the slot this cycle if id_valid=1.
REQ-013 id_valid  out  1  output slot holds an instruction.
REQ-014 id_pc  out  32  PC of the slot instruction.
REQ-015 id_inst  out  32  slot instruction.
REQ-016 id_adel  out  1  slot instruction raised a fetch address error.

Function
REQ-017 FSM states SHALL be IDLE, WAIT and DISCARD, with at most one outstanding bus request.
REQ-018 slot_free SHALL equal !id_valid | id_allowin.
REQ-019 In IDLE: inst_req = slot_free & !flush; inst_addr = {pc[31:2],2'b00}.
REQ-020 IDLE with inst_req & inst_addr_ok: req_pc<=pc, next state WAIT, fetch_stall=0 this cycle.
REQ-021 fetch_stall SHALL be 1 in every cycle except the cycle of REQ-020 or REQ-033.
REQ-022 IDLE without acceptance: no state change; inst_addr may change with pc while unaccepted.
REQ-023 WAIT: inst_req=0; on inst_data_ok, slot <= {1, req_pc, inst_rdata, 0}, next state IDLE (response-to-slot latency 1 cycle).
REQ-024 The slot is guaranteed free when data returns, because issue requires slot_free; data SHALL never be dropped except under flush.
REQ-025 When id_valid & id_allowin and no load occurs, id_valid SHALL clear next cycle.
REQ-026 flush in IDLE: no request, id_valid<=0.
REQ-027 flush in WAIT with inst_data_ok in the same cycle: data dropped, id_valid<=0, next state IDLE.
REQ-028 flush in WAIT without inst_data_ok: id_valid<=0, next state DISCARD.
REQ-029 DISCARD: inst_req=0; on inst_data_ok, data dropped and next state IDLE; a further flush leaves the state in DISCARD.
REQ-030 Back-to-back fetch: data_ok at cycle N and a new acceptance at N+1 SHALL sustain one instruction per 2 cycles with a 1-cycle bus.

Reset
REQ-031 reset SHALL force state=IDLE, id_valid=0, id_pc=0, id_inst=0, id_adel=0 and req_pc=0; while reset=1: inst_req=0, fetch_stall=1.
REQ-032 inst_data_ok in the first cycle after reset SHALL be ignored; the bus resets in the same cycle.

Configuration
REQ-033 With FETCH_ADEL_EN defined: in IDLE, if pc[1:0]!=0, inst_req=0; if slot_free & !flush, slot <= {1, pc, NOP_INST, 1} and fetch_stall=0.
REQ-034 Without FETCH_ADEL_EN: pc[1:0] ignored, id_adel tied 0, no address check.

Structure
REQ-035 Package fetch_pkg SHALL hold the FSM state encoding, NOP_INST default and RESET_ADDR 32'hbfc0_0000.
REQ-036 Optional sub-module inst_slot SHALL hold the output register (load/consume/clear).

Verification
REQ-037 Reset released, pc=bfc0_0000, addr_ok=1, data_ok next cycle with rdata=2408_0001 -> id_valid=1, id_pc=bfc0_0000, id_inst=2408_0001.
REQ-038 addr_ok held 0 for 3 cycles -> fetch_stall=1 and inst_req=1 for 3 cycles; acceptance on 4th cycle -> fetch_stall=0 once.
REQ-039 id_allowin=0 with id_valid=1 -> inst_req=0, slot unchanged; id_allowin=1 -> request issued in the same cycle.
REQ-040 flush in WAIT, data_ok 2 cycles later -> data dropped, id_valid stays 0, next request at pc=bfc0_0380.
REQ-041 FETCH_ADEL_EN, pc=bfc0_0002 -> no inst_req; id_adel=1, id_inst=NOP_INST, id_pc=bfc0_0002.
REQ-042 reset asserted in WAIT -> IDLE, id_valid=0; stray data_ok after reset ignored.
